// File: rtl/palette_stage_if.sv
// Palette write port: requester drives address/data/request, the palette stage answers with ready.
interface palette_stage_if #(
  parameter int CBITS = 4,
  parameter int DW    = 6
);
  logic              wr_req;
  logic [CBITS-1:0]  wr_addr;
  logic [3*DW-1:0]   wr_data;
  logic              wr_ready;

  modport master (output wr_req, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/palette_stage.sv
// Writable palette output stage: self-initialising grey-ramp RAM, two-stage pixel pipeline on ce_pix,
// tear-free single-entry write holding register and optional monochrome luma output.
module palette_stage #(
  parameter int CBITS = 4,
  parameter int DW    = 6,
  parameter int SAFE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             de,
  input  logic [CBITS-1:0] color,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             mono,
  palette_stage_if.slave   wr,
  output logic             init_done,
  output logic [3*DW-1:0]  rgb,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
);
  localparam int STAGES = 2;
  localparam int NENT   = 1 << CBITS;
  localparam int EW     = 3 * DW;

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [CBITS-1:0] addr;
    logic [EW-1:0]    data;
  } wr_hold_t;

  state_t           state;
  logic [CBITS-1:0] init_cnt;
  logic             pending;
  wr_hold_t         hold;
  logic             commit;

  logic [EW-1:0]    ram [NENT];
  logic [STAGES:1]  vld_pipe, hs_pipe, vs_pipe;
  logic [CBITS-1:0] s1_color;
  logic [EW-1:0]    s2_data;
  logic             s2_mono;

  // Grey ramp: the index bits repeated MSB-first until DW bits are filled.
  function automatic logic [DW-1:0] ramp(input logic [CBITS-1:0] k);
    logic [DW-1:0] ch;
    for (int i = 0; i < DW; i++) ch[DW-1-i] = k[CBITS-1-(i % CBITS)];
    return ch;
  endfunction

  assign wr.wr_ready = init_done & ~pending;
  assign commit      = pending & ((SAFE == 0) | ~de);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      pending   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == CBITS'(NENT - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (commit)
            pending <= 1'b0;
          else if (wr.wr_req && wr.wr_ready) begin
            pending <= 1'b1;
            hold    <= '{addr: wr.wr_addr, data: wr.wr_data};
          end
        end
      endcase
    end
  end

  // Read-before-write: a same-address read on a commit edge sees the old entry.
  always_ff @(posedge clock) begin
    if (!reset && state == INIT)
      ram[init_cnt] <= {3{ramp(init_cnt)}};
    else if (!reset && commit)
      ram[hold.addr] <= hold.data;
    if (ce_pix)
      s2_data <= ram[s1_color];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      s1_color <= '0;
      s2_mono  <= 1'b0;
    end else if (ce_pix) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], de};
      hs_pipe  <= {hs_pipe[STAGES-1:1], hsync};
      vs_pipe  <= {vs_pipe[STAGES-1:1], vsync};
      s1_color <= color;
      s2_mono  <= mono;
    end
  end

  logic [DW-1:0] ch_r, ch_g, ch_b, luma;
  logic [DW+2:0] luma_sum;

  // 2R + 5G + B never exceeds 8*(2^DW-1), so the shifted sum always fits DW bits.
  assign {ch_r, ch_g, ch_b} = s2_data;
  assign luma_sum = {2'b00, ch_r, 1'b0} + {1'b0, ch_g, 2'b00} + {3'b000, ch_g} + {3'b000, ch_b};
  assign luma     = luma_sum[DW+2:3];

  always_comb begin
    rgb = '0;
    if (vld_pipe[STAGES])
      rgb = s2_mono ? {3{luma}} : s2_data;
  end

  assign hsync_o = hs_pipe[STAGES];
  assign vsync_o = vs_pipe[STAGES];
  assign de_o    = vld_pipe[STAGES];
endmodule

// File: tb/tb_palette_stage.sv
// Bench for palette_stage: SAFE=1 and SAFE=0 instances side by side, checked every clock against a palette model.
module tb_palette_stage;
  localparam int CBITS = 4;
  localparam int DW    = 6;
  localparam int EW    = 18;
  localparam int NENT  = 16;

  logic clock = 1'b0, reset = 1'b1, ce_pix = 1'b0, de = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, mono = 1'b0;
  logic [CBITS-1:0] color = '0;
  logic wr_req = 1'b0;
  logic [CBITS-1:0] wr_addr = '0;
  logic [EW-1:0] wr_data = '0;

  logic [1:0]         done_v, hso_v, vso_v, deo_v;
  logic [1:0][EW-1:0] rgb_v;

  palette_stage_if #(.CBITS(CBITS), .DW(DW)) wif_s ();
  palette_stage_if #(.CBITS(CBITS), .DW(DW)) wif_f ();
  assign wif_s.wr_req = wr_req;  assign wif_s.wr_addr = wr_addr;  assign wif_s.wr_data = wr_data;
  assign wif_f.wr_req = wr_req;  assign wif_f.wr_addr = wr_addr;  assign wif_f.wr_data = wr_data;

  palette_stage #(.CBITS(CBITS), .DW(DW), .SAFE(1)) u_safe (
    .clock(clock), .reset(reset), .ce_pix(ce_pix), .de(de), .color(color),
    .hsync(hsync), .vsync(vsync), .mono(mono), .wr(wif_s), .init_done(done_v[0]),
    .rgb(rgb_v[0]), .hsync_o(hso_v[0]), .vsync_o(vso_v[0]), .de_o(deo_v[0]));

  palette_stage #(.CBITS(CBITS), .DW(DW), .SAFE(0)) u_fast (
    .clock(clock), .reset(reset), .ce_pix(ce_pix), .de(de), .color(color),
    .hsync(hsync), .vsync(vsync), .mono(mono), .wr(wif_f), .init_done(done_v[1]),
    .rgb(rgb_v[1]), .hsync_o(hso_v[1]), .vsync_o(vso_v[1]), .de_o(deo_v[1]));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0, tick_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  // Reference palette, write port and pixel history
  typedef struct packed { logic de, hs, vs; logic [CBITS-1:0] color; } pix_t;
  logic [EW-1:0] m_pal [2][NENT];
  bit            m_ok  [2][NENT];
  bit            m_pend[2];
  logic [CBITS-1:0] m_wa[2];
  logic [EW-1:0] m_wd[2];
  bit            m_done = 0;
  int            m_k = 0;
  pix_t          prev = '0;
  logic [EW-1:0] e_rgb[2];
  bit            e_known[2];
  bit            e_de = 0, e_hs = 0, e_vs = 0;
  bit            acc[2];

  function automatic logic [EW-1:0] ramp_ent(input int k);
    logic [11:0] rep;
    logic [5:0]  ch;
    rep = {3{k[3:0]}};
    ch  = rep[11:6];
    return {ch, ch, ch};
  endfunction

  function automatic logic [EW-1:0] shade(input logic [EW-1:0] e, input logic mn);
    int r, g, b, l;
    logic [5:0] c;
    if (!mn) return e;
    r = int'(e[17:12]); g = int'(e[11:6]); b = int'(e[5:0]);
    l = (2 * r + 5 * g + b) / 8;
    c = l[5:0];
    return {c, c, c};
  endfunction

  task automatic tick();
    bit rdy[2], cm[2];
    for (int d = 0; d < 2; d++) begin
      rdy[d] = m_done && !m_pend[d];
      cm[d]  = m_pend[d] && (d == 1 || !de);
    end
    if (!reset) begin
      chk("wr_ready_s", wif_s.wr_ready, rdy[0]);
      chk("wr_ready_f", wif_f.wr_ready, rdy[1]);
    end
    @(posedge clock);
    tick_no++;
    acc = '{0, 0};
    if (reset) begin
      m_k = 0; m_done = 0; m_pend = '{0, 0}; prev = '0;
      e_rgb = '{0, 0}; e_known = '{1, 1}; e_de = 0; e_hs = 0; e_vs = 0;
    end else begin
      if (ce_pix) begin
        e_de = prev.de; e_hs = prev.hs; e_vs = prev.vs;
        for (int d = 0; d < 2; d++) begin
          if (!prev.de) begin
            e_rgb[d] = '0; e_known[d] = 1;
          end else begin
            e_known[d] = m_ok[d][prev.color];
            e_rgb[d]   = shade(m_pal[d][prev.color], mono);
          end
        end
        prev = '{de: de, hs: hsync, vs: vsync, color: color};
      end
      for (int d = 0; d < 2; d++) begin
        if (cm[d]) begin
          m_pal[d][m_wa[d]] = m_wd[d]; m_ok[d][m_wa[d]] = 1; m_pend[d] = 0;
        end else if (wr_req && rdy[d]) begin
          acc[d] = 1; m_pend[d] = 1; m_wa[d] = wr_addr; m_wd[d] = wr_data;
        end
      end
      if (!m_done) begin
        for (int d = 0; d < 2; d++) begin
          m_pal[d][m_k] = ramp_ent(m_k); m_ok[d][m_k] = 1;
        end
        if (m_k == NENT - 1) m_done = 1;
        m_k++;
      end
    end
    #1;
    chk("de_o_s", deo_v[0], e_de);       chk("de_o_f", deo_v[1], e_de);
    chk("hsync_o_s", hso_v[0], e_hs);    chk("hsync_o_f", hso_v[1], e_hs);
    chk("vsync_o_s", vso_v[0], e_vs);    chk("vsync_o_f", vso_v[1], e_vs);
    chk("init_done_s", done_v[0], m_done); chk("init_done_f", done_v[1], m_done);
    if (e_known[0]) chk("rgb_s", rgb_v[0], e_rgb[0]);
    if (e_known[1]) chk("rgb_f", rgb_v[1], e_rgb[1]);
  endtask

  task automatic strobe();
    ce_pix = 1'b1; tick(); ce_pix = 1'b0;
  endtask

  task automatic s4();
    repeat (3) tick();
    strobe();
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    while (!done_v[0] && cnt < 40) begin tick(); cnt++; end
    chk(tag, cnt, 16);
  endtask

  initial begin
    int first, second;
    // reset, then init with ce_pix idle
    reset = 1'b1; repeat (3) tick(); reset = 1'b0;
    wait_init("init_latency");

    // reads at one strobe every 4 clocks
    de = 1; color = 15; s4();
    color = 0; s4();
    chk("read15", rgb_v[0], 18'h3FFFF);
    color = 8; hsync = 1; s4();
    chk("read0", rgb_v[0], 18'h0);
    chk("hsync_lag", hso_v[0], 1'b0);
    hsync = 0; s4();
    chk("read8", rgb_v[0], {3{6'b100010}});
    chk("hsync_aligned", hso_v[0], 1'b1);
    tick(); tick();
    chk("read8_hold", rgb_v[0], {3{6'b100010}});
    de = 0; s4(); s4();
    chk("de_low_black", rgb_v[0], 18'h0);

    // SAFE=1 write during the active line
    de = 1; color = 3; strobe(); strobe();
    wr_req = 1; wr_addr = 3; wr_data = 18'h3F000; tick(); wr_req = 0;
    chk("safe_ready_drop", wif_s.wr_ready, 1'b0);
    repeat (4) strobe();
    chk("safe_old_in_line", rgb_v[0], ramp_ent(3));
    chk("safe_still_pending", wif_s.wr_ready, 1'b0);
    de = 0; tick();
    chk("safe_ready_back", wif_s.wr_ready, 1'b1);
    de = 1; color = 3; strobe(); strobe();
    chk("safe_new_value", rgb_v[0], 18'h3F000);

    // SAFE=0: same-address read on the commit edge returns the old entry
    color = 6; strobe();
    wr_req = 1; wr_addr = 6; wr_data = 18'h2A555; tick(); wr_req = 0;
    strobe();
    chk("fast_old_on_commit", rgb_v[1], ramp_ent(6));
    strobe();
    chk("fast_new_next", rgb_v[1], 18'h2A555);

    // SAFE=0 back-to-back with wr_req held
    de = 0; wr_req = 1; wr_addr = 7; wr_data = 18'h01234; first = -1; second = -1;
    for (int i = 0; i < 12 && second < 0; i++) begin
      tick();
      if (acc[1]) begin
        if (first < 0) begin first = tick_no; wr_addr = 9; wr_data = 18'h3C3C3; end
        else second = tick_no;
      end
    end
    wr_req = 0;
    chk("b2b_gap", second - first, 2);
    de = 1; color = 9; strobe(); strobe();
    chk("b2b_second_data", rgb_v[1], 18'h3C3C3);

    // mono
    de = 0; repeat (3) tick();
    wr_req = 1; wr_addr = 10; wr_data = 18'h3F000; tick(); wr_req = 0; tick(); tick();
    wr_req = 1; wr_addr = 11; wr_data = 18'h3FFFF; tick(); wr_req = 0; tick(); tick();
    mono = 1; de = 1; color = 10; strobe(); strobe();
    chk("mono_red_s", rgb_v[0], {3{6'd15}});
    chk("mono_red_f", rgb_v[1], {3{6'd15}});
    color = 11; strobe(); strobe();
    chk("mono_white", rgb_v[0], {3{6'd63}});
    mono = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ce_pix  = ($urandom % 3) == 0;
      de      = ($urandom % 4) != 0;
      color   = 4'($urandom);
      hsync   = 1'($urandom);
      vsync   = 1'($urandom);
      mono    = ($urandom % 8) == 0;
      wr_req  = ($urandom % 3) == 0;
      wr_addr = 4'($urandom);
      wr_data = 18'($urandom);
      tick();
    end
    ce_pix = 0; mono = 0; wr_req = 0; hsync = 0; vsync = 0;

    // reset with a write pending, then again mid-init
    de = 0; repeat (3) tick();
    de = 1; wr_req = 1; wr_addr = 12; wr_data = 18'h12345; tick();
    chk("pend_before_reset", wif_s.wr_ready, 1'b0);
    reset = 1; tick(); tick(); reset = 0;
    repeat (7) tick();
    reset = 1; tick(); reset = 0; wr_req = 0;
    wait_init("reinit_latency");
    color = 12; strobe(); strobe();
    chk("reset_drop_s", rgb_v[0], ramp_ent(12));
    chk("reset_drop_f", rgb_v[1], ramp_ent(12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
